// File: rtl/sort_stream_adapter.sv
// Stream front end for the 8-entry byte sorter: loads a frame over valid/ready,
// runs the sorter, then streams the sorted bytes back out with a last flag.
module sort_stream_adapter #(
  parameter int DEPTH  = 8,
  parameter int AW     = 3,
  parameter int DW     = 8,
  parameter int RD_LAT = 2,
  parameter int WR_GAP = 2
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          srt_start,
  output logic          srt_wr,
  output logic [AW-1:0] srt_addr,
  output logic [DW-1:0] srt_datain,
  input  logic [DW-1:0] srt_dataout,
  input  logic          srt_ready
);

  localparam int CMAX = ((RD_LAT > WR_GAP) ? RD_LAT : WR_GAP) + 4;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] GAP_END   = CW'(WR_GAP - 1);
  localparam logic [CW-1:0] RD_END    = CW'(RD_LAT);
  localparam logic [CW-1:0] LO_IGNORE = CW'(2);
  localparam logic [CW-1:0] LO_LIMIT  = CW'(3);
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    LOAD,
    GAP,
    START,
    WAIT_LO,
    WAIT_HI,
    READ,
    OUT
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] index, index_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          last_idx;

  logic          in_ready_n, busy_n, srt_start_n, srt_wr_n;
  logic          out_valid_n, out_last_n;
  logic [AW-1:0] srt_addr_n;
  logic [DW-1:0] srt_datain_n, out_data_n;

  assign last_idx = (index == LAST_IDX);

  // Every output is a flop so the sorter and both streams see glitch-free signals.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= LOAD;
      index      <= '0;
      cnt        <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      srt_start  <= 1'b0;
      srt_wr     <= 1'b0;
      srt_addr   <= '0;
      srt_datain <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
    end else begin
      state      <= state_n;
      index      <= index_n;
      cnt        <= cnt_n;
      in_ready   <= in_ready_n;
      busy       <= busy_n;
      srt_start  <= srt_start_n;
      srt_wr     <= srt_wr_n;
      srt_addr   <= srt_addr_n;
      srt_datain <= srt_datain_n;
      out_valid  <= out_valid_n;
      out_last   <= out_last_n;
      out_data   <= out_data_n;
    end
  end

  always_comb begin
    state_n      = state;
    index_n      = index;
    cnt_n        = cnt;
    srt_start_n  = 1'b0;
    srt_wr_n     = 1'b0;
    srt_addr_n   = srt_addr;
    srt_datain_n = srt_datain;
    out_valid_n  = out_valid;
    out_last_n   = out_last;
    out_data_n   = out_data;

    case (state)
      LOAD: begin
        if (in_valid && in_ready) begin
          srt_wr_n     = 1'b1;
          srt_addr_n   = index;
          srt_datain_n = in_data;
          if (last_idx) begin
            index_n = '0;
            cnt_n   = '0;
            state_n = GAP;
          end else begin
            index_n = index + AW'(1);
          end
        end
      end

      GAP: begin
        if (cnt == GAP_END) begin
          state_n = START;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      START: begin
        srt_start_n = 1'b1;
        cnt_n       = '0;
        state_n     = WAIT_LO;
      end

      // The sorter drops ready a cycle late, so the first look is deferred and a
      // sorter that never drops ready is not waited on forever.
      WAIT_LO: begin
        if ((cnt >= LO_IGNORE) && (!srt_ready || (cnt == LO_LIMIT))) begin
          state_n = WAIT_HI;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      WAIT_HI: begin
        if (srt_ready) begin
          index_n    = '0;
          cnt_n      = '0;
          srt_addr_n = '0;
          state_n    = READ;
        end
      end

      READ: begin
        if (cnt == RD_END) begin
          out_data_n  = srt_dataout;
          out_valid_n = 1'b1;
          out_last_n  = last_idx;
          state_n     = OUT;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      OUT: begin
        if (out_valid && out_ready) begin
          out_valid_n = 1'b0;
          out_last_n  = 1'b0;
          cnt_n       = '0;
          if (last_idx) begin
            index_n = '0;
            state_n = LOAD;
          end else begin
            index_n    = index + AW'(1);
            srt_addr_n = index + AW'(1);
            state_n    = READ;
          end
        end
      end

      default: begin
        state_n = LOAD;
      end
    endcase

    in_ready_n = (state_n == LOAD);
    busy_n     = (state_n != LOAD);
  end

endmodule

// File: tb/tb_sort_stream_adapter.sv
// Bench for sort_stream_adapter: behavioural sorter, scoreboard that sorts each
// accepted frame, table vectors, reset corner cases and randomized frames.
module tb_sort_stream_adapter;

  localparam int WR_GAP   = 2;
  localparam int SORT_CYC = 6;

  logic       clk;
  logic       nrst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic       srt_start;
  logic       srt_wr;
  logic [2:0] srt_addr;
  logic [7:0] srt_datain;
  logic [7:0] srt_dataout;
  logic       srt_ready;

  sort_stream_adapter #(
    .DEPTH(8), .AW(3), .DW(8), .RD_LAT(2), .WR_GAP(WR_GAP)
  ) dut (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy),
    .srt_start(srt_start), .srt_wr(srt_wr), .srt_addr(srt_addr), .srt_datain(srt_datain),
    .srt_dataout(srt_dataout), .srt_ready(srt_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic logic [63:0] sort8(input logic [63:0] v);
    logic [7:0] a [8];
    logic [7:0] t;
    logic [63:0] r;
    for (int i = 0; i < 8; i++) a[i] = v[i*8 +: 8];
    for (int i = 1; i < 8; i++) begin
      for (int j = i; j > 0; j--) begin
        if (a[j-1] > a[j]) begin
          t = a[j]; a[j] = a[j-1]; a[j-1] = t;
        end
      end
    end
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = a[i];
    return r;
  endfunction

  function automatic logic [63:0] mk(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
    return {b7, b6, b5, b4, b3, b2, b1, b0};
  endfunction

  // Behavioural sorter: 2-cycle read pipe, ready drops one cycle after start.
  logic [63:0] mem;
  logic [7:0]  rd_pipe;
  logic        pend;
  int          sort_cnt;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      srt_ready   <= 1'b1;
      pend        <= 1'b0;
      sort_cnt    <= 0;
      rd_pipe     <= 8'h00;
      srt_dataout <= 8'h00;
    end else begin
      if (srt_wr) mem[int'(srt_addr)*8 +: 8] <= srt_datain;
      rd_pipe     <= mem[int'(srt_addr)*8 +: 8];
      srt_dataout <= rd_pipe;
      pend        <= srt_start;
      if (pend) begin
        srt_ready <= 1'b0;
        sort_cnt  <= SORT_CYC;
      end else if (!srt_ready) begin
        if (sort_cnt == 0) begin
          srt_ready <= 1'b1;
          mem       <= sort8(mem);
        end else begin
          sort_cnt <= sort_cnt - 1;
        end
      end
    end
  end

  // Scoreboard and protocol monitor, sampling on the falling edge.
  logic [7:0]  in_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  out_log[$];
  bit          exp_busy  = 1'b0;
  bit          skip_rdy  = 1'b0;
  bit          hold      = 1'b0;
  int          wr_cnt    = 0;
  int          starts    = 0;
  int          out_pos   = 0;
  int          since_wr  = 100;
  logic [7:0]  prev_data;
  logic        prev_last;
  logic [2:0]  prev_addr;
  logic [63:0] mon_pack;
  logic [63:0] mon_sorted;

  initial begin
    forever begin
      @(negedge clk);
      if (!nrst) begin
        in_q.delete();
        exp_q.delete();
        exp_busy = 1'b0;
        skip_rdy = 1'b1;
        hold     = 1'b0;
        wr_cnt   = 0;
        starts   = 0;
        out_pos  = 0;
        since_wr = 100;
      end else begin
        if (since_wr < 1000) since_wr++;
        check("busy", busy, exp_busy);
        if (skip_rdy) skip_rdy = 1'b0;
        else check("in_ready", in_ready, !exp_busy);
        if (out_valid) check("out_valid_outside_load", busy, 1);
        if (hold) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, prev_data);
          check("hold_last", out_last, prev_last);
          check("hold_addr", srt_addr, prev_addr);
        end
        if (srt_wr) begin
          check("wr_addr", srt_addr, wr_cnt);
          check("wr_with_start", srt_start, 0);
          wr_cnt++;
          since_wr = 0;
        end
        if (srt_start) begin
          check("start_gap", since_wr > WR_GAP, 1);
          check("writes_before_start", wr_cnt, 8);
          check("start_count", starts, 0);
          check("start_while_busy", busy, 1);
          starts++;
        end
        if (in_valid && in_ready) begin
          in_q.push_back(in_data);
          if (in_q.size() == 8) begin
            for (int i = 0; i < 8; i++) mon_pack[i*8 +: 8] = in_q[i];
            mon_sorted = sort8(mon_pack);
            for (int i = 0; i < 8; i++) exp_q.push_back(mon_sorted[i*8 +: 8]);
            in_q.delete();
            exp_busy = 1'b1;
          end
        end
        if (out_valid && out_ready) begin
          out_log.push_back(out_data);
          check("start_before_output", starts, 1);
          if (exp_q.size() == 0) begin
            timeout_fail("unexpected_output");
          end else begin
            check("out_data", out_data, exp_q.pop_front());
          end
          check("out_last", out_last, out_pos == 7);
          out_pos++;
          if (out_pos == 8) begin
            out_pos  = 0;
            exp_busy = 1'b0;
            wr_cnt   = 0;
            starts   = 0;
          end
        end
        hold      = out_valid && !out_ready;
        prev_data = out_data;
        prev_last = out_last;
        prev_addr = srt_addr;
      end
    end
  end

  task automatic applyStimulus(input logic [63:0] bytes, input int gap, input bit rnd_gap);
    int n;
    bit acc;
    int g;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = bytes[i*8 +: 8];
      n   = 0;
      acc = 1'b0;
      while (!acc && n < 400) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        n++;
      end
      in_valid = 1'b0;
      if (!acc) timeout_fail("input_accept");
      g = rnd_gap ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic checkOutput(input logic [63:0] exp, input int base);
    for (int i = 0; i < 8; i++) begin
      if (out_log.size() > base + i) check("frame_byte", out_log[base + i], exp[i*8 +: 8]);
      else timeout_fail("frame_byte_missing");
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_busy && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_busy) timeout_fail("frame_drain");
    check("in_ready_after_frame", in_ready, 1);
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) timeout_fail("out_valid_wait");
  endtask

  task automatic pop_one();
    wait_out_valid();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic checkReset();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_srt_start", srt_start, 0);
    check("rst_srt_wr", srt_wr, 0);
    check("rst_srt_addr", srt_addr, 0);
    check("rst_srt_datain", srt_datain, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    nrst = 1'b0;
    #1;
    checkReset();
    @(posedge clk);
    #1;
    nrst = 1'b1;
    check("in_ready_before_sampled_release", in_ready, 0);
    @(posedge clk);
    #1;
    check("in_ready_after_release", in_ready, 1);
  endtask

  typedef struct packed {
    logic [63:0] in_bytes;
    logic [63:0] exp_bytes;
    logic [7:0]  gap;
    logic [7:0]  stall;
  } vec_t;

  vec_t vecs [4];
  bit   stop_rnd;
  int   n_wait;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0].in_bytes  = mk(8, 3, 5, 1, 7, 2, 6, 4);
    vecs[0].exp_bytes = mk(1, 2, 3, 4, 5, 6, 7, 8);
    vecs[0].gap       = 8'd0;
    vecs[0].stall     = 8'hFF;
    vecs[1].in_bytes  = mk(8'h80, 8'h00, 8'hFF, 8'h10, 8'h10, 8'h7F, 8'h01, 8'hFE);
    vecs[1].exp_bytes = mk(8'h00, 8'h01, 8'h10, 8'h10, 8'h7F, 8'h80, 8'hFE, 8'hFF);
    vecs[1].gap       = 8'd2;
    vecs[1].stall     = 8'hFF;
    vecs[2].in_bytes  = mk(8'h42, 8'h17, 8'hA0, 8'h03, 8'h99, 8'h55, 8'h17, 8'h00);
    vecs[2].exp_bytes = mk(8'h00, 8'h03, 8'h17, 8'h17, 8'h42, 8'h55, 8'h99, 8'hA0);
    vecs[2].gap       = 8'd0;
    vecs[2].stall     = 8'd2;
    vecs[3].in_bytes  = mk(9, 9, 0, 0, 3, 3, 1, 1);
    vecs[3].exp_bytes = mk(0, 0, 1, 1, 3, 3, 9, 9);
    vecs[3].gap       = 8'd1;
    vecs[3].stall     = 8'hFF;

    nrst      = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    #2;
    nrst = 1'b0;
    #1;
    checkReset();
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    check("in_ready_before_sampled_release", in_ready, 0);
    @(posedge clk);
    #1;
    check("in_ready_after_release", in_ready, 1);

    // Table frames: plain, gapped input, and a 20-cycle stall on the third byte.
    for (int v = 0; v < 3; v++) begin
      out_log.delete();
      out_ready = (vecs[v].stall == 8'hFF);
      applyStimulus(vecs[v].in_bytes, int'(vecs[v].gap), 1'b0);
      if (vecs[v].stall != 8'hFF) begin
        repeat (int'(vecs[v].stall)) pop_one();
        wait_out_valid();
        repeat (20) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      wait_idle();
      checkOutput(vecs[v].exp_bytes, 0);
    end

    $display("[TB] back-to-back frames");
    out_log.delete();
    out_ready = 1'b1;
    applyStimulus(mk(0, 1, 2, 3, 4, 5, 6, 7), 0, 1'b0);
    applyStimulus(mk(7, 6, 5, 4, 3, 2, 1, 0), 0, 1'b0);
    wait_idle();
    check("b2b_count", out_log.size(), 16);
    checkOutput(mk(0, 1, 2, 3, 4, 5, 6, 7), 0);
    checkOutput(mk(0, 1, 2, 3, 4, 5, 6, 7), 8);

    $display("[TB] reset while waiting for sorter");
    applyStimulus(mk(5, 4, 3, 2, 1, 0, 7, 6), 0, 1'b0);
    n_wait = 0;
    while (srt_ready && n_wait < 50) begin
      @(posedge clk);
      #1;
      n_wait++;
    end
    if (srt_ready) timeout_fail("sorter_busy_wait");
    check("busy_in_wait_hi", busy, 1);
    pulse_reset();

    $display("[TB] reset during fifth output byte");
    out_ready = 1'b0;
    applyStimulus(mk(2, 7, 1, 8, 2, 8, 1, 8), 0, 1'b0);
    repeat (4) pop_one();
    wait_out_valid();
    pulse_reset();
    out_ready = 1'b1;

    out_log.delete();
    applyStimulus(vecs[3].in_bytes, int'(vecs[3].gap), 1'b0);
    wait_idle();
    checkOutput(vecs[3].exp_bytes, 0);

    $display("[TB] randomized frames");
    for (int r = 0; r < 6; r++) begin
      out_log.delete();
      stop_rnd = 1'b0;
      fork
        begin
          applyStimulus({$urandom, $urandom}, 0, 1'b1);
          wait_idle();
          stop_rnd = 1'b1;
        end
        begin
          while (!stop_rnd) begin
            @(posedge clk);
            #1;
            out_ready = 1'($urandom_range(0, 1));
          end
        end
      join
      out_ready = 1'b1;
      check("rand_count", out_log.size(), 8);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
